// File: rtl/clk_to_hs_source.sv
// Clocked source feeding a 4-phase return-to-zero bundled-data pipeline.
// Buffers words from a valid/ready port and replays each one as a req/ack cycle.
module clk_to_hs_source #(
  parameter int              N        = 1,
  parameter int              DEPTH    = 2,
  parameter int              SYNC     = 2,
  parameter logic [N-1:0]    RdataVal = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         v_i,
  output logic         rdy_i,
  input  logic [N-1:0] d_i,
  output logic         r_o,
  input  logic         a_o,
  output logic [N-1:0] d_o,
  output logic [1:0]   dbg_state
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    REQ   = 2'd2,
    RTZ   = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [N-1:0]     mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [SYNC-1:0]  ack_sync;
  logic             a_s;
  logic             empty, full, push, load, r_n;

  // Upstream handshake: a word transfers on any rising edge where v_i and rdy_i are both high.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdy_i = !full;
  assign push  = v_i && !full;
  assign a_s   = ack_sync[SYNC-1];
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= d_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ack_sync <= '0;
      state    <= IDLE;
      r_o      <= 1'b0;
      d_o      <= RdataVal;
    end else begin
      ack_sync <= {ack_sync[SYNC-2:0], a_o};
      state    <= state_n;
      r_o      <= r_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        rd_ptr <= rd_ptr + 1'b1;
        d_o    <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  // A new word is only loaded while the synchronised ack is low, so d_o never moves mid-handshake.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    r_n     = r_o;
    case (state)
      IDLE: begin
        if (!empty && !a_s) begin
          load    = 1'b1;
          state_n = SETUP;
        end
      end
      SETUP: begin
        r_n     = 1'b1;
        state_n = REQ;
      end
      REQ: begin
        if (a_s) begin
          r_n     = 1'b0;
          state_n = RTZ;
        end
      end
      RTZ: begin
        if (!a_s) begin
          if (!empty) begin
            load    = 1'b1;
            state_n = SETUP;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        r_n     = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_clk_to_hs_source.sv
// Self-checking bench for clk_to_hs_source: cycle tables, directed corner cases,
// and a random 4-phase responder with an ordered scoreboard.
module tb_clk_to_hs_source;
  localparam int N = 8;
  localparam int DEPTH = 2;
  localparam int SYNC = 2;
  localparam logic [N-1:0] RV = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic v_i = 1'b0;
  logic rdy_i, r_o, a_o;
  logic ideal_ack = 1'b0;
  logic a_drv = 1'b0;
  logic [N-1:0] d_i = '0;
  logic [N-1:0] d_o;
  logic [1:0] dbg_state;

  int n_pass = 0;
  int n_total = 0;
  logic [N-1:0] exp_q[$];
  logic rand_done = 1'b0;

  typedef struct {
    logic         v;
    logic [N-1:0] d;
    logic         rdy;
    logic         r;
    logic [N-1:0] dexp;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  // Ideal downstream mirrors r_o with zero delay; otherwise the bench drives ack directly.
  assign a_o = ideal_ack ? r_o : a_drv;

  clk_to_hs_source #(.N(N), .DEPTH(DEPTH), .SYNC(SYNC), .RdataVal(RV)) dut (
    .clk(clk), .rst(rst), .v_i(v_i), .rdy_i(rdy_i), .d_i(d_i),
    .r_o(r_o), .a_o(a_o), .d_o(d_o), .dbg_state(dbg_state)
  );

  initial begin
    #900000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset(input logic ideal, input logic ack);
    @(negedge clk);
    rst = 1'b0; v_i = 1'b0; d_i = '0; ideal_ack = ideal; a_drv = ack;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Row i drives inputs before edge i and checks outputs at the following negedge.
  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      v_i = tbl[i].v; d_i = tbl[i].d;
      @(negedge clk);
      check($sformatf("%s_rdy_e%0d", name, i), rdy_i, tbl[i].rdy);
      check($sformatf("%s_r_e%0d", name, i), r_o, tbl[i].r);
      check($sformatf("%s_d_e%0d", name, i), d_o, tbl[i].dexp);
    end
    v_i = 1'b0;
  endtask

  task automatic drive_words;
    for (int w = 0; w < 1000; w++) begin
      int t;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      v_i = 1'b1;
      d_i = N'($urandom_range(0, 255));
      t = 0;
      while (!rdy_i && t < 500) begin @(negedge clk); t++; end
      if (!rdy_i) begin
        check("drv_timeout", rdy_i, 1);
        v_i = 1'b0;
        break;
      end
      exp_q.push_back(d_i);
      @(negedge clk);
      v_i = 1'b0;
    end
  endtask

  task automatic respond_words;
    for (int w = 0; w < 1000; w++) begin
      int t;
      t = 0;
      while (!r_o && t < 500) begin @(negedge clk); t++; end
      if (!r_o) begin check("rsp_timeout", r_o, 1); break; end
      if (exp_q.size() == 0) check("rsp_unexpected_word", d_o, 0);
      else check($sformatf("order_w%0d", w), d_o, exp_q.pop_front());
      repeat ($urandom_range(0, 4)) @(negedge clk);
      a_drv = 1'b1;
      t = 0;
      while (r_o && t < 500) begin @(negedge clk); t++; end
      if (r_o) begin check("rtz_timeout", r_o, 0); break; end
      repeat ($urandom_range(0, 4)) @(negedge clk);
      a_drv = 1'b0;
      @(negedge clk);
    end
    rand_done = 1'b1;
  endtask

  task automatic watch_stable;
    logic [N-1:0] prev_d;
    logic prev_busy;
    prev_d = d_o; prev_busy = r_o | a_o;
    while (!rand_done) begin
      @(negedge clk);
      if (prev_busy) check("d_stable", d_o, prev_d);
      prev_busy = r_o | a_o;
      prev_d = d_o;
    end
  endtask

  initial begin
    // Test 1: single word, ideal downstream.
    do_reset(1'b1, 1'b0);
    check("rst_r", r_o, 0);
    check("rst_d", d_o, RV);
    check("rst_rdy", rdy_i, 1);
    check("rst_state", dbg_state, 0);
    tbl.delete();
    tbl.push_back('{1'b1, 8'h05, 1'b1, 1'b0, RV});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h05});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 8'h05});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 8'h05});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 8'h05});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h05});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h05});
    run_table("single");

    // Test 2: four back-to-back words, 7-cycle period, r_o rises at edges 2, 9, 16, 23.
    do_reset(1'b1, 1'b0);
    tbl.delete();
    for (int e = 0; e < 28; e++) begin
      vec_t row;
      int k;
      row.v = (e <= 9);
      row.d = (e < 3) ? N'(e + 1) : 8'h04;
      row.rdy = !((e >= 2 && e <= 7) || (e >= 9 && e <= 14));
      row.r = 1'b0;
      for (int j = 0; j < 4; j++) if (e >= 2 + 7 * j && e <= 4 + 7 * j) row.r = 1'b1;
      k = (e - 1) / 7;
      if (k > 3) k = 3;
      row.dexp = (e < 1) ? RV : N'(k + 1);
      tbl.push_back(row);
    end
    run_table("b2b");

    // Test 3: ack held low, FIFO fills, extra word refused.
    do_reset(1'b0, 1'b0);
    v_i = 1'b1; d_i = 8'h11; @(negedge clk);
    d_i = 8'h22; @(negedge clk);
    d_i = 8'h33; @(negedge clk);
    check("full_rdy", rdy_i, 0);
    check("full_r", r_o, 1);
    d_i = 8'h44;
    repeat (3) @(negedge clk);
    check("full_hold_rdy", rdy_i, 0);
    check("full_hold_d", d_o, 8'h11);
    v_i = 1'b0;
    a_drv = 1'b1;
    repeat (2) @(negedge clk);
    check("ack_sync_r_still_high", r_o, 1);
    @(negedge clk);
    check("ack_r_fall", r_o, 0);
    check("ack_d_hold", d_o, 8'h11);
    a_drv = 1'b0;
    repeat (2) @(negedge clk);
    check("rtz_no_load_yet", d_o, 8'h11);
    check("rtz_rdy_still_low", rdy_i, 0);
    @(negedge clk);
    check("rtz_load", d_o, 8'h22);
    check("rtz_rdy_back", rdy_i, 1);
    ideal_ack = 1'b1;
    repeat (7) @(negedge clk);
    check("third_word", d_o, 8'h33);
    repeat (10) @(negedge clk);
    check("refused_word_absent", d_o, 8'h33);
    check("drained_rdy", rdy_i, 1);
    check("drained_r", r_o, 0);

    // Test 4: ack stuck high after reset blocks issue.
    do_reset(1'b0, 1'b1);
    repeat (4) @(negedge clk);
    v_i = 1'b1; d_i = 8'h55; @(negedge clk);
    v_i = 1'b0;
    repeat (6) @(negedge clk);
    check("stuck_r", r_o, 0);
    check("stuck_d", d_o, RV);
    check("stuck_rdy", rdy_i, 1);
    check("stuck_state", dbg_state, 0);
    a_drv = 1'b0;
    repeat (2) @(negedge clk);
    check("unstick_wait", d_o, RV);
    @(negedge clk);
    check("unstick_load", d_o, 8'h55);
    check("unstick_setup_r", r_o, 0);
    @(negedge clk);
    check("unstick_req", r_o, 1);
    ideal_ack = 1'b1;
    repeat (2) @(negedge clk);
    check("unstick_req_hold", r_o, 1);
    @(negedge clk);
    check("unstick_rtz", r_o, 0);

    // Test 5: asynchronous reset in the middle of a request.
    do_reset(1'b0, 1'b0);
    v_i = 1'b1; d_i = 8'h61; @(negedge clk);
    d_i = 8'h62; @(negedge clk);
    d_i = 8'h63; @(negedge clk);
    v_i = 1'b0;
    check("midreq_r", r_o, 1);
    #2 rst = 1'b0;
    #1;
    check("async_r", r_o, 0);
    check("async_d", d_o, RV);
    check("async_rdy", rdy_i, 1);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_r_%0d", i), r_o, 0);
      check($sformatf("post_rst_rdy_%0d", i), rdy_i, 1);
      check($sformatf("post_rst_d_%0d", i), d_o, RV);
    end

    // Test 6: random traffic against a random-delay responder.
    do_reset(1'b0, 1'b0);
    exp_q.delete();
    rand_done = 1'b0;
    fork
      drive_words();
      respond_words();
      watch_stable();
    join
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/clk_to_hs_source.md
Name: clk_to_hs_source

Overview:
- Clocked-domain source that feeds a 4-phase bundled-data handshake pipeline, i.e. the stage directly upstream of the first handshake latch.
- Accepts words on a synchronous valid/ready interface and buffers them in a small FIFO.
- Replays each word on a return-to-zero req/ack channel: r_o high, wait ack, r_o low, wait ack low.
- a_o is asynchronous to clk and is synchronised internally.

Parameters:
- N, 1, data width in bits.
- DEPTH, 2, FIFO entries; power of two, >= 2.
- SYNC, 2, ack synchroniser flop count; >= 2.
- RdataVal, 0 (N bits), reset value of d_o.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous active-low reset; rst=0 resets immediately, release synchronous to clk by system.
- v_i  input  1  upstream word valid.
- rdy_i  output  1  upstream ready; transfer when v_i & rdy_i at a clk edge.
- d_i  input  N  upstream data.
- r_o  output  1  request to downstream handshake stage (registered).
- a_o  input  1  acknowledge from downstream (asynchronous).
- d_o  output  N  bundled data to downstream (registered).

Behaviour:
- Reset (rst=0): FIFO empty, FSM=IDLE, r_o=0, d_o=RdataVal, synchroniser flops=0, rdy_i=1 after release. Reset mid-handshake aborts the word in flight and discards FIFO contents; downstream shares rst and is reset too.
- FIFO:
  - rdy_i = !full (combinational from pointers).
  - Push on v_i&rdy_i; pop only on FSM load.
  - Push and pop in the same cycle allowed; count unchanged.
  - Pointers wrap modulo DEPTH; full/empty distinguished by an extra pointer bit.
  - No push when full; no pop when empty.
- a_s: a_o passed through SYNC flops clocked by clk, reset to 0. FSM uses only a_s.
- FSM states:
  - IDLE: if !empty & !a_s -> load d_o<=head, pop, go SETUP. Otherwise stay. a_s=1 in IDLE (ack stuck high after reset) blocks issue until low.
  - SETUP: one cycle with d_o stable, r_o still 0 (bundled-data setup margin). Next edge: r_o<=1, go REQ.
  - REQ: hold r_o=1, d_o stable. On edge with a_s=1: r_o<=0, go RTZ.
  - RTZ: hold r_o=0, d_o stable. On edge with a_s=0: if !empty, load+pop and go SETUP; else go IDLE.
- d_o changes only on a load edge, and never while r_o=1 or between r_o fall and a_s low.
- Ack glitches or rises in IDLE/SETUP are ignored, apart from the IDLE block above.
- Latency, empty source accepting at edge t0:
  - load at t0+1; r_o rises at t0+2.
- Throughput with an ideal downstream (a_o follows r_o, zero delay), r_o rising at edge t:
  - r_o falls at t+SYNC+1.
  - Next load at t+2*SYNC+2.
  - Next r_o rise at t+2*SYNC+3.
  - Period 2*SYNC+3 (7 cycles for SYNC=2).
- r_o and d_o are flop outputs; no combinational path from a_o to any output.

Test Plan:
- Reset with a_o=0, then push 0x5 (N=4) at edge 0 -> d_o=0x5 after edge 1, r_o=1 after edge 2; a_o:=r_o gives r_o=0 after edge 5.
- Ideal downstream, 4 back-to-back words 1,2,3,4, SYNC=2 -> r_o rises at edges 2, 9, 16, 23. d_o matches each word and is stable through each r_o-high window. rdy_i drops once the FIFO holds DEPTH words.
- Hold a_o=0 with r_o=1, push until full (DEPTH=2) -> rdy_i=0, further v_i ignored. Raise a_o -> r_o falls; after a_o falls the next word loads and rdy_i=1 the following cycle.
- a_o=1 at reset release with FIFO loaded -> r_o stays 0, no load. Drop a_o -> load after SYNC+1 edges, normal handshake follows.
- Assert rst=0 asynchronously mid-REQ with 2 words queued -> r_o=0 and d_o=RdataVal immediately. After release, rdy_i=1, FIFO empty, no request issued.
- Random v_i plus a random-delay 4-phase responder, 1000 words -> sequence at downstream ack edges equals input order. No d_o change while r_o=1 or while ack is high.
